// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI slave transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CMD       = 4'd1,
    S_DECODE    = 4'd2,
    S_RD_LOAD   = 4'd3,
    S_RD_SHIFT  = 4'd4,
    S_RD_NEXT   = 4'd5,
    S_WR_SHIFT  = 4'd6,
    S_WR_COMMIT = 4'd7,
    S_WR_NEXT   = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  // Shift register mode encodings
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b01;
  localparam logic [1:0] SR_LOAD  = 2'b10;

  // Command byte LSB values
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_bit_counter.sv
// Counts SCLK rising-edge pulses modulo DATA_W; flags the pulse that completes a byte.
module spi_bit_counter #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap after the final bit of a byte
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = en & ~clr & (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_txn_sequencer.sv
// SPI slave transaction sequencer: command byte decode, byte-wise read/write
// sequencing of the shift register and data memory. Defining SPI_SEQ_BURST_EN
// enables multi-byte frames with address auto-increment.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk_pe,
  input  logic [DATA_W-1:0] pout,
  output logic [1:0]        sr_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              miso_en,
  output logic              busy,
  output logic              byte_done
);

  state_t            state_q, state_d;
  logic              cs_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        sr_mode_q, sr_mode_d;
  logic              mem_we_q, mem_we_d;
  logic              miso_en_q, miso_en_d;
  logic              busy_q, busy_d;
  logic              byte_done_q, byte_done_d;
  logic              cnt_en_s, cnt_clr_s, bit_last_s;

  // Only the three shifting states count edges; pulses elsewhere are dropped
  always_comb begin
    cnt_clr_s = cs | (state_q == S_IDLE);
    if ((state_q == S_CMD) || (state_q == S_RD_SHIFT) || (state_q == S_WR_SHIFT)) begin
      cnt_en_s = sclk_pe & ~cs;
    end else begin
      cnt_en_s = 1'b0;
    end
  end

  spi_bit_counter #(.DATA_W(DATA_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .last  (bit_last_s)
  );

  // Next-state, address and byte-done logic; a high cs aborts from any state
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    byte_done_d = 1'b0;
    if (cs) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_q) state_d = S_CMD;
          else      state_d = S_IDLE;
        end
        S_CMD: begin
          if (bit_last_s) state_d = S_DECODE;
          else            state_d = S_CMD;
        end
        S_DECODE: begin
          mem_addr_d = pout[ADDR_W:1];
          if (pout[0] == RW_READ)       state_d = S_RD_LOAD;
          else if (pout[0] == RW_WRITE) state_d = S_WR_SHIFT;
          else                          state_d = S_IDLE;
        end
        S_RD_LOAD: state_d = S_RD_SHIFT;
        S_RD_SHIFT: begin
          if (bit_last_s) begin
            byte_done_d = 1'b1;
`ifdef SPI_SEQ_BURST_EN
            state_d = S_RD_NEXT;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_RD_SHIFT;
          end
        end
        S_WR_SHIFT: begin
          // byte_done is raised together with the commit strobe
          if (bit_last_s) begin
            byte_done_d = 1'b1;
            state_d     = S_WR_COMMIT;
          end else begin
            state_d = S_WR_SHIFT;
          end
        end
        S_WR_COMMIT: begin
`ifdef SPI_SEQ_BURST_EN
          state_d = S_WR_NEXT;
`else
          state_d = S_DONE;
`endif
        end
`ifdef SPI_SEQ_BURST_EN
        S_RD_NEXT: begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          state_d    = S_RD_LOAD;
        end
        S_WR_NEXT: begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          state_d    = S_WR_SHIFT;
        end
`endif
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q
  always_comb begin
    case (state_d)
      S_CMD, S_RD_SHIFT, S_WR_SHIFT: sr_mode_d = SR_SHIFT;
      S_RD_LOAD:                     sr_mode_d = SR_LOAD;
      default:                       sr_mode_d = SR_HOLD;
    endcase
    miso_en_d = (state_d == S_RD_SHIFT);
    mem_we_d  = (state_d == S_WR_COMMIT);
    busy_d    = (state_d != S_IDLE);
  end

  // State, address and output registers; cs history starts idle-high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cs_q        <= 1'b1;
      mem_addr_q  <= '0;
      sr_mode_q   <= SR_HOLD;
      mem_we_q    <= 1'b0;
      miso_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs;
      mem_addr_q  <= mem_addr_d;
      sr_mode_q   <= sr_mode_d;
      mem_we_q    <= mem_we_d;
      miso_en_q   <= miso_en_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign sr_mode   = sr_mode_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign miso_en   = miso_en_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer with a behavioural shift register
// and 128-byte memory around the sequencer.
module tb_spi_txn_sequencer;

`ifdef SPI_SEQ_BURST_EN
  localparam int BX = 1;
`else
  localparam int BX = 0;
`endif

  logic       clk, reset, cs, sclk_pe, mosi, mem_clr;
  logic [7:0] pout_m;
  logic [1:0] sr_mode;
  logic [6:0] mem_addr;
  logic       mem_we, miso_en, busy, byte_done;
  logic [7:0] mem [128];

  int n_err = 0;
  int n_checks = 0;
  int we_cnt = 0, bd_cnt = 0, ld_cnt = 0;

  spi_txn_sequencer #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sclk_pe   (sclk_pe),
    .pout      (pout_m),
    .sr_mode   (sr_mode),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .miso_en   (miso_en),
    .busy      (busy),
    .byte_done (byte_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register (MSB first) and memory model
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      pout_m <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= pout_m;
      if (sr_mode == 2'b10) pout_m <= mem[mem_addr];
      else if (sr_mode == 2'b01 && sclk_pe) pout_m <= {pout_m[6:0], mosi};
    end
  end

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (byte_done) bd_cnt++;
    if (sr_mode == 2'b10) ld_cnt++;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nbits;
    int          exp_we;
    int          exp_bd;
    int          exp_ld;
    int          exp_miso;
    logic [31:0] exp_rd;
    logic [6:0]  chk_addr;
    logic [7:0]  chk_val;
  } vec_t;

  function automatic vec_t mk(logic [7:0] c, logic [31:0] d, int nb, int we, int bd,
                              int ld, int mi, logic [31:0] rd, logic [6:0] ca, logic [7:0] cv);
    vec_t v;
    v.cmd = c; v.data = d; v.nbits = nb; v.exp_we = we; v.exp_bd = bd;
    v.exp_ld = ld; v.exp_miso = mi; v.exp_rd = rd; v.chk_addr = ca; v.chk_val = cv;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    mosi = b;
    sclk_pe = 1'b1;
    @(negedge clk);
    sclk_pe = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                           output logic [31:0] rd, output int nmiso);
    rd = 32'h0;
    nmiso = 0;
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    for (int i = nbits - 1; i >= 0; i--) begin
      rd = {rd[30:0], pout_m[7] & miso_en};
      if (miso_en) nmiso++;
      send_bit(data[i]);
    end
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  vec_t        vq[$];
  logic [31:0] rd;
  int          nmiso, we0, bd0, ld0;

  initial begin
    reset = 1'b1; cs = 1'b1; sclk_pe = 1'b0; mosi = 1'b0; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {17'h0, sr_mode, mem_addr, mem_we, miso_en, busy, byte_done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    mem_clr = 1'b0;
    @(negedge clk);

    //                cmd    data          nb  we      bd      ld      miso rd            addr   val
    vq.push_back(mk(8'h0A, 32'h3C,       8,  1,      1,      0,      0,   32'h0,        7'd5,  8'h3C));
    vq.push_back(mk(8'h0B, 32'h0,        8,  0,      1,      1 + BX, 8,   32'h3C,       7'd5,  8'h3C));
    vq.push_back(mk(8'hFE, 32'hA5,       8,  1,      1,      0,      0,   32'h0,        7'd127,8'hA5));
    vq.push_back(mk(8'hFF, 32'h0,        8,  0,      1,      1 + BX, 8,   32'hA5,       7'd127,8'hA5));
    vq.push_back(mk(8'h14, 32'hFF,       5,  0,      0,      0,      0,   32'h0,        7'd10, 8'h00));
    vq.push_back(mk(8'h0B, 32'h0,        3,  0,      0,      1,      3,   32'h1,        7'd5,  8'h3C));
    vq.push_back(mk(8'h14, 32'h6699,     16, 1 + BX, 1 + BX, 0,      0,   32'h0,        7'd11, (BX == 1) ? 8'h99 : 8'h00));
    vq.push_back(mk(8'h15, 32'h0,        8,  0,      1,      1 + BX, 8,   32'h66,       7'd10, 8'h66));
`ifdef SPI_SEQ_BURST_EN
    vq.push_back(mk(8'hFE, 32'h112233,   24, 3,      3,      0,      0,   32'h0,        7'd0,  8'h22));
    vq.push_back(mk(8'hFF, 32'h0,        16, 0,      2,      3,      16,  32'h1122,     7'd1,  8'h33));
`endif

    for (int i = 0; i < vq.size(); i++) begin
      we0 = we_cnt; bd0 = bd_cnt; ld0 = ld_cnt;
      run_frame(vq[i].cmd, vq[i].data, vq[i].nbits, rd, nmiso);
      check($sformatf("v%0d_mem_we_pulses", i), we_cnt - we0, vq[i].exp_we);
      check($sformatf("v%0d_byte_done_pulses", i), bd_cnt - bd0, vq[i].exp_bd);
      check($sformatf("v%0d_load_cycles", i), ld_cnt - ld0, vq[i].exp_ld);
      check($sformatf("v%0d_miso_en_bits", i), nmiso, vq[i].exp_miso);
      check($sformatf("v%0d_miso_data", i), rd, vq[i].exp_rd);
      check($sformatf("v%0d_mem_value", i), {24'h0, mem[vq[i].chk_addr]}, {24'h0, vq[i].chk_val});
      check($sformatf("v%0d_idle_after_cs", i), {28'h0, busy, miso_en, sr_mode}, 32'h0);
    end

    // Abort in CMD: cs rises after 4 command bits; nothing written, back to idle next cycle
    we0 = we_cnt;
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("cmd_abort_busy_before", {31'h0, busy}, 32'h1);
    cs = 1'b1;
    @(negedge clk);
    check("cmd_abort_busy_after", {31'h0, busy}, 32'h0);
    check("cmd_abort_no_we", we_cnt - we0, 32'h0);

    // Reset in the middle of a read byte: outputs clear without a clock edge
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) send_bit(((8'h0B >> i) & 8'h01) != 8'h00);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    check("pre_reset_in_rd_shift", {30'h0, miso_en, busy}, 32'h3);
    check("pre_reset_addr", {25'h0, mem_addr}, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {17'h0, sr_mode, mem_addr, mem_we, miso_en, busy, byte_done}, 32'h0);
    @(negedge clk);
    cs = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    ld0 = ld_cnt;
    run_frame(8'h0B, 32'h0, 8, rd, nmiso);
    check("post_reset_read_data", rd, 32'h3C);
    check("post_reset_read_loads", ld_cnt - ld0, 1 + BX);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Transaction controller for the SPI slave datapath: decodes each chip-select frame into an address/command byte followed by data bytes, and sequences the shift register, the 128-byte data memory and the MISO output enable. It takes conditioned CS and SCLK edge pulses from the input conditioners and the shift register's parallel output. It owns the memory address and drives the memory write strobe. An optional burst mode streams consecutive addresses within one frame.

## Interface
- `ADDR_W`, default 7: memory address width; the command byte is {addr[ADDR_W-1:0], rw}.
- `DATA_W`, default 8: byte width; the bit counter counts DATA_W SCLK rising edges.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  conditioned chip select, active low; high = idle.
- `sclk_pe`  in  1  one-`clk` pulse per conditioned SCLK rising edge.
- `pout`  in  DATA_W  shift register parallel output.
- `sr_mode`  out  2  shift register mode: 00 HOLD, 01 SHIFT (shift on `sclk_pe`), 10 LOAD (parallel load from memory).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write strobe, one `clk` wide.
- `miso_en`  out  1  gates serial out onto MISO.
- `busy`  out  1  high whenever state ≠ IDLE.
- `byte_done`  out  1  one-`clk` pulse when a data byte completes.

## Operation
- States: IDLE, CMD, DECODE, RD_LOAD, RD_SHIFT, RD_NEXT, WR_SHIFT, WR_COMMIT, WR_NEXT, DONE.
- IDLE: `sr_mode`=HOLD. Falling `cs` → CMD, bit counter cleared.
- CMD: `sr_mode`=SHIFT. Count `sclk_pe`. On the 8th → DECODE.
- DECODE, one cycle: latch `mem_addr`=`pout[7:1]`; rw=`pout[0]`. rw=1 → RD_LOAD; rw=0 → WR_SHIFT.
- RD_LOAD, one cycle: `sr_mode`=LOAD. → RD_SHIFT.
- RD_SHIFT: `sr_mode`=SHIFT, `miso_en`=1. On the 8th `sclk_pe`, pulse `byte_done`, then → RD_NEXT with burst or → DONE without.
- RD_NEXT: `mem_addr`+1 → RD_LOAD.
- WR_SHIFT: `sr_mode`=SHIFT. On the 8th `sclk_pe` → WR_COMMIT.
- WR_COMMIT, one cycle: `mem_we`=1 at current `mem_addr`; pulse `byte_done`. Then → WR_NEXT with burst or → DONE without.
- WR_NEXT: `mem_addr`+1 → WR_SHIFT.
- DONE: `sr_mode`=HOLD, `miso_en`=0. Further `sclk_pe` pulses are ignored until `cs` rises.
- `cs` high in any state → IDLE on the next `clk`, regardless of the bit count. A partial write byte is never committed. `mem_we` is never asserted on the abort cycle.
- Address increment wraps modulo 2^ADDR_W: 127 → 0.

## Timing
- Reset value of every output is 0: `sr_mode`=00, `mem_addr`=0, `mem_we`=0, `miso_en`=0, `busy`=0, `byte_done`=0. State = IDLE.
- All outputs are registered.
- Read data is loaded 2 `clk` after the command byte's 8th `sclk_pe` (DECODE, then RD_LOAD). The memory read is combinational on `mem_addr`.
- Write commits exactly 1 `clk` after the 8th data `sclk_pe`.
- `sclk_pe` pulses must be spaced ≥ 4 `clk` apart. Pulses landing in DECODE, RD_LOAD, RD_NEXT, WR_COMMIT or WR_NEXT are a protocol violation and are not counted.
- If `sclk_pe` and rising `cs` occur in the same cycle, `cs` wins.

## Configuration
- `SPI_SEQ_BURST_EN` defined: a frame carries unlimited data bytes with auto-increment (RD_NEXT/WR_NEXT paths active).
- Not defined: exactly one data byte per frame. After it → DONE. RD_NEXT/WR_NEXT are not synthesized and `mem_addr` never increments.

## Structure
- Package `spi_seq_pkg`:
  - state enum;
  - `SR_HOLD`, `SR_SHIFT`, `SR_LOAD` mode constants;
  - `RW_READ`/`RW_WRITE` bit values.
- Sub-module `spi_bit_counter`: counts `sclk_pe` modulo DATA_W, has a synchronous clear, and outputs a `last` flag on the DATA_W-th pulse.

## Test plan
- Single write: cs low, shift 0x0A (addr 0x05, write) then 0x3C, cs high → one `mem_we` pulse with `mem_addr`=0x05. Memory[5]=0x3C.
- Single read: memory[5]=0x3C, shift 0x0B → `sr_mode`=LOAD for 1 cycle, `miso_en`=1 for 8 SCLK edges. The MISO bit sequence is 0,0,1,1,1,1,0,0.
- Burst write (`SPI_SEQ_BURST_EN`): command 0xFE (addr 127, write) plus 3 data bytes → writes at 127, 0, 1 (wrap).
- Abort: cs rises after 5 data bits of a write → no `mem_we`, state IDLE, `busy`=0 next cycle.
- Reset asserted mid-RD_SHIFT → all outputs 0 immediately, no clock required. A subsequent frame behaves normally.
- Non-burst build, 2 data bytes in one write frame → only the first byte is committed, the second is ignored in DONE.
